// File: rtl/uart_tx_arbiter.sv
// -----------------------------------------------------------------------------
// uart_tx_arbiter
//
// Purpose:
//   Shares one UART transmitter between two byte requesters. A round-robin
//   pointer picks the winner of a tie. A requester that wins is locked in as
//   owner until it sends a byte marked "last", so a packet is never split.
//   Each accepted byte is handed to the transmitter with a one-cycle start
//   pulse. If the transmitter does not raise tx_busy within TIMEOUT_CNT
//   cycles, the byte is dropped and the lock is released.
//
// Ports:
//   clk, rst_n               clock (rising edge), asynchronous active-low reset
//   reqN_valid/data/last     requester N offers a byte; last marks packet end
//   reqN_ready               requester N byte accepted this cycle
//   tx_data, tx_start        byte and one-cycle start pulse to the transmitter
//   tx_busy                  transmitter is shifting a frame
//   grant                    one-hot current owner, 2'b00 when nobody owns it
//   timeout_err              one-cycle pulse when tx_busy never rose
//   dbg_state_o              current FSM state, for observation only
//
// Handshake: a byte moves on a rising edge where reqN_valid && reqN_ready are
// both high. A requester keeps valid, data and last stable until it sees
// ready. ready is combinational from the registered state and the valids. It
// is only high in IDLE, for at most one requester, and never during reset.
// -----------------------------------------------------------------------------
module uart_tx_arbiter #(
  parameter int TIMEOUT_CNT = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req0_valid,
  input  logic [7:0] req0_data,
  input  logic       req0_last,
  output logic       req0_ready,
  input  logic       req1_valid,
  input  logic [7:0] req1_data,
  input  logic       req1_last,
  output logic       req1_ready,
  output logic [7:0] tx_data,
  output logic       tx_start,
  input  logic       tx_busy,
  output logic [1:0] grant,
  output logic       timeout_err,
  output logic [1:0] dbg_state_o
);

  localparam int CW = $clog2(TIMEOUT_CNT) + 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CNT - 1);
  localparam logic [CW-1:0] CNT_MAX  = {CW{1'b1}};

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    START     = 2'd1,
    WAIT_ACK  = 2'd2,
    WAIT_DONE = 2'd3
  } state_e;

  state_e          state_q, state_d;
  logic            rr_q, rr_d;         // requester that wins the next tie
  logic            lock_q, lock_d;     // owner holds the channel mid-packet
  logic            owner_q, owner_d;   // 0 = requester 0, 1 = requester 1
  logic            last_q, last_d;     // captured last flag of byte in flight
  logic [7:0]      tx_data_q, tx_data_d;
  logic [CW-1:0]   cnt_q, cnt_d;       // cycles spent waiting for tx_busy

  logic            sel_valid;
  logic            sel_id;
  logic            timeout_pulse;

  // Winner selection. This only happens in IDLE. While locked, only the
  // owner is considered. rst_n gates the result so that ready stays low
  // while reset is held, even if the requesters are presenting data.
  always_comb begin
    sel_valid = 1'b0;
    sel_id    = 1'b0;
    if (rst_n && (state_q == IDLE)) begin
      if (lock_q) begin
        sel_valid = owner_q ? req1_valid : req0_valid;
        sel_id    = owner_q;
      end else if (req0_valid && req1_valid) begin
        sel_valid = 1'b1;
        sel_id    = rr_q;
      end else if (req0_valid) begin
        sel_valid = 1'b1;
        sel_id    = 1'b0;
      end else if (req1_valid) begin
        sel_valid = 1'b1;
        sel_id    = 1'b1;
      end
    end
  end

  always_comb begin
    state_d       = state_q;
    rr_d          = rr_q;
    lock_d        = lock_q;
    owner_d       = owner_q;
    last_d        = last_q;
    tx_data_d     = tx_data_q;
    cnt_d         = cnt_q;
    timeout_pulse = 1'b0;
    case (state_q)
      IDLE: begin
        if (sel_valid) begin
          owner_d   = sel_id;
          lock_d    = 1'b1;
          last_d    = sel_id ? req1_last : req0_last;
          tx_data_d = sel_id ? req1_data : req0_data;
          state_d   = START;
        end
      end
      START: begin
        cnt_d   = '0;
        state_d = WAIT_ACK;
      end
      WAIT_ACK: begin
        if (tx_busy) begin
          state_d = WAIT_DONE;
        end else if (cnt_q == CNT_LAST) begin
          // The transmitter never started. The byte is dropped, the lock is
          // released, and rr stays as it was, because the packet did not
          // finish normally.
          timeout_pulse = 1'b1;
          lock_d        = 1'b0;
          state_d       = IDLE;
        end else if (cnt_q != CNT_MAX) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      WAIT_DONE: begin
        if (!tx_busy) begin
          state_d = IDLE;
          if (last_q) begin
            lock_d = 1'b0;
            rr_d   = ~owner_q;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      rr_q      <= 1'b0;
      lock_q    <= 1'b0;
      owner_q   <= 1'b0;
      last_q    <= 1'b0;
      tx_data_q <= 8'h00;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      rr_q      <= rr_d;
      lock_q    <= lock_d;
      owner_q   <= owner_d;
      last_q    <= last_d;
      tx_data_q <= tx_data_d;
      cnt_q     <= cnt_d;
    end
  end

  assign req0_ready  = sel_valid & ~sel_id;
  assign req1_ready  = sel_valid &  sel_id;
  assign tx_data     = tx_data_q;
  assign tx_start    = (state_q == START);
  assign timeout_err = timeout_pulse;
  // The owner stays visible for as long as it holds the lock or has a byte
  // in flight. The latter covers the final cycle of a packet.
  assign grant       = (lock_q || (state_q != IDLE)) ? (owner_q ? 2'b10 : 2'b01) : 2'b00;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// -----------------------------------------------------------------------------
// tb_uart_tx_arbiter
//
// Bench for uart_tx_arbiter. Requester sources are fed from byte queues, and
// a transmitter stub raises tx_busy for busy_len cycles after each start.
// A transaction-level model predicts ready/tx_start/timeout_err/grant/tx_data
// every cycle. Directed tests also pin acceptance order, latencies and reset
// behaviour with literal values.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_uart_tx_arbiter;

  localparam int T = 8;

  // ---------------- clock / reset / DUT ----------------
  logic       clk = 1'b0;
  logic       rst_n;
  logic       req0_valid, req0_last, req0_ready;
  logic       req1_valid, req1_last, req1_ready;
  logic [7:0] req0_data, req1_data, tx_data;
  logic       tx_start, tx_busy, timeout_err;
  logic [1:0] grant, dbg_state;

  always #5 clk = ~clk;

  uart_tx_arbiter #(.TIMEOUT_CNT(T)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req0_valid  (req0_valid),
    .req0_data   (req0_data),
    .req0_last   (req0_last),
    .req0_ready  (req0_ready),
    .req1_valid  (req1_valid),
    .req1_data   (req1_data),
    .req1_last   (req1_last),
    .req1_ready  (req1_ready),
    .tx_data     (tx_data),
    .tx_start    (tx_start),
    .tx_busy     (tx_busy),
    .grant       (grant),
    .timeout_err (timeout_err),
    .dbg_state_o (dbg_state)
  );

  // ---------------- shared bench state ----------------
  int n_chk = 0;
  int n_err = 0;
  int cyc   = 0;

  logic [8:0] src0[$];          // {last, data} to offer on requester 0
  logic [8:0] src1[$];
  int         rd0 = 0;
  int         rd1 = 0;
  int         busy_len = 10;    // tx_busy length per frame, 0 = never busy

  logic [8:0] exp_q[$];         // expected acceptances {who, data}
  logic [8:0] act_q[$];         // observed acceptances {who, data}
  int         acc_cyc_q[$];     // cycle of each observed acceptance
  int         act_rd = 0;
  int         last_start_cyc = -1;
  int         last_to_cyc = -1;

  // model: byte in flight has an age counted from its tx_start cycle (0)
  int         m_age = -1;
  bit         m_acked = 0;
  bit         m_locked = 0;
  bit         m_last = 0;
  int         m_owner = 0;
  int         m_rr = 0;
  logic [7:0] m_data = 8'h00;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, want %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- driver: sources and transmitter stub ----------------
  initial begin : source
    bit a0, a1, st;
    int busy_cnt;
    busy_cnt   = 0;
    req0_valid = 1'b0; req0_data = 8'h00; req0_last = 1'b0;
    req1_valid = 1'b0; req1_data = 8'h00; req1_last = 1'b0;
    tx_busy    = 1'b0;
    forever begin
      @(negedge clk);
      a0 = req0_valid && req0_ready;
      a1 = req1_valid && req1_ready;
      st = tx_start;
      @(posedge clk);
      #1;
      if (a0) rd0++;
      if (a1) rd1++;
      if (rd0 < src0.size()) begin
        req0_valid = 1'b1;
        {req0_last, req0_data} = src0[rd0];
      end else begin
        req0_valid = 1'b0; req0_last = 1'b0; req0_data = 8'h00;
      end
      if (rd1 < src1.size()) begin
        req1_valid = 1'b1;
        {req1_last, req1_data} = src1[rd1];
      end else begin
        req1_valid = 1'b0; req1_last = 1'b0; req1_data = 8'h00;
      end
      if (!rst_n) busy_cnt = 0;
      else if (st) busy_cnt = busy_len;
      if (busy_cnt > 0) begin
        tx_busy = 1'b1;
        busy_cnt--;
      end else begin
        tx_busy = 1'b0;
      end
    end
  end

  // ---------------- model + per-cycle compare ----------------
  initial begin : compare
    int         win;
    bit         in_flight;
    logic       e_r0, e_r1, e_st, e_to;
    logic [1:0] e_gr;
    logic [7:0] e_d;
    forever begin
      @(negedge clk);
      cyc++;
      win = -1;
      in_flight = 1'b0;
      if (!rst_n) begin
        m_age = -1; m_acked = 0; m_locked = 0; m_last = 0;
        m_owner = 0; m_rr = 0; m_data = 8'h00;
        e_r0 = 1'b0; e_r1 = 1'b0; e_st = 1'b0; e_to = 1'b0;
        e_gr = 2'b00; e_d = 8'h00;
      end else begin
        in_flight = (m_age >= 0);
        if (!in_flight) begin
          if (m_locked) begin
            if (m_owner == 0 && req0_valid) win = 0;
            if (m_owner == 1 && req1_valid) win = 1;
          end else if (req0_valid && req1_valid) win = m_rr;
          else if (req0_valid) win = 0;
          else if (req1_valid) win = 1;
        end
        e_r0 = (win == 0);
        e_r1 = (win == 1);
        e_st = (m_age == 0);
        e_to = in_flight && !m_acked && (m_age == T) && !tx_busy;
        e_gr = (m_locked || in_flight) ? ((m_owner == 1) ? 2'b10 : 2'b01) : 2'b00;
        e_d  = m_data;
      end
      chk("req0_ready", 32'(req0_ready), 32'(e_r0));
      chk("req1_ready", 32'(req1_ready), 32'(e_r1));
      chk("tx_start", 32'(tx_start), 32'(e_st));
      chk("timeout_err", 32'(timeout_err), 32'(e_to));
      chk("grant", 32'(grant), 32'(e_gr));
      chk("tx_data", 32'(tx_data), 32'(e_d));

      if (tx_start) last_start_cyc = cyc;
      if (timeout_err) last_to_cyc = cyc;
      if (req0_valid && req0_ready) begin
        act_q.push_back({1'b0, req0_data});
        acc_cyc_q.push_back(cyc);
      end
      if (req1_valid && req1_ready) begin
        act_q.push_back({1'b1, req1_data});
        acc_cyc_q.push_back(cyc);
      end

      if (rst_n) begin
        if (win >= 0) begin
          m_owner  = win;
          m_locked = 1;
          m_age    = 0;
          m_acked  = 0;
          m_data   = (win == 1) ? req1_data : req0_data;
          m_last   = (win == 1) ? req1_last : req0_last;
        end else if (in_flight) begin
          if (m_acked) begin
            if (!tx_busy) begin
              m_age   = -1;
              m_acked = 0;
              if (m_last) begin
                m_locked = 0;
                m_rr     = 1 - m_owner;
              end
            end
          end else if (m_age >= 1 && tx_busy) begin
            m_acked = 1;
          end else if (e_to) begin
            m_age    = -1;
            m_locked = 0;
          end else begin
            m_age++;
          end
        end
      end
    end
  end

  // ---------------- helper tasks ----------------
  task automatic push(input int who, input logic [7:0] d, input logic l);
    if (who == 0) src0.push_back({l, d});
    else src1.push_back({l, d});
  endtask

  task automatic expect_acc(input int who, input logic [7:0] d);
    exp_q.push_back({who[0], d});
  endtask

  task automatic wait_drain(input string name, input int budget);
    int n;
    n = 0;
    while (!(rd0 == src0.size() && rd1 == src1.size() && m_age < 0)) begin
      @(posedge clk);
      #1;
      n++;
      if (n > budget) begin
        n_chk++;
        n_err++;
        $display("FAIL %s_drain: still busy after %0d cycles, want done", name, budget);
        break;
      end
    end
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic check_order(input string name);
    logic [8:0] e;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      if (act_rd < act_q.size()) begin
        chk(name, 32'(act_q[act_rd]), 32'(e));
        act_rd++;
      end else begin
        n_chk++;
        n_err++;
        $display("FAIL %s_missing: got no acceptance, want %0h", name, e);
      end
    end
    chk({name, "_extra"}, 32'(act_q.size() - act_rd), 0);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  // ---------------- watchdog ----------------
  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1, "watchdog expired");
  end

  // ---------------- directed tests + report ----------------
  initial begin : main
    int base, n, rel;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_outputs", 32'({tx_data, tx_start, req0_ready, req1_ready, grant, timeout_err, dbg_state}), 0);
    rst_n = 1'b1;

    // single byte, 10-cycle busy
    busy_len = 10;
    push(0, 8'h55, 1'b1);
    expect_acc(0, 8'h55);
    wait_drain("single", 200);
    check_order("single_order");
    chk("single_start_latency", 32'(last_start_cyc - acc_cyc_q[acc_cyc_q.size()-1]), 1);
    chk("single_tx_data", 32'(tx_data), 32'h55);
    chk("single_grant_after", 32'(grant), 0);

    // tie with rr=1 after the single byte from requester 0
    busy_len = 2;
    push(0, 8'hA0, 1'b1);
    push(1, 8'hB0, 1'b1);
    expect_acc(1, 8'hB0);
    expect_acc(0, 8'hA0);
    wait_drain("tie_rr1", 200);
    check_order("tie_rr1_order");

    // tie from reset, four single-byte packets at minimum spacing
    do_reset();
    busy_len = 1;
    push(0, 8'h01, 1'b1);
    push(0, 8'h02, 1'b1);
    push(1, 8'h11, 1'b1);
    push(1, 8'h12, 1'b1);
    expect_acc(0, 8'h01);
    expect_acc(1, 8'h11);
    expect_acc(0, 8'h02);
    expect_acc(1, 8'h12);
    base = act_rd;
    wait_drain("alt", 200);
    if (base + 3 < acc_cyc_q.size()) begin
      for (int i = 0; i < 3; i++)
        chk("alt_spacing", 32'(acc_cyc_q[base+i+1] - acc_cyc_q[base+i]), 4);
    end else begin
      n_chk++;
      n_err++;
      $display("FAIL alt_spacing: got %0d acceptances, want 4", acc_cyc_q.size() - base);
    end
    check_order("alt_order");

    // packet lock: requester 1 waits for requester 0's 3-byte packet
    busy_len = 3;
    push(0, 8'h21, 1'b0);
    push(0, 8'h22, 1'b0);
    push(0, 8'h23, 1'b1);
    push(1, 8'hC1, 1'b1);
    expect_acc(0, 8'h21);
    expect_acc(0, 8'h22);
    expect_acc(0, 8'h23);
    expect_acc(1, 8'hC1);
    wait_drain("lock", 300);
    check_order("lock_order");

    // owner goes quiet mid-packet and keeps the lock
    push(0, 8'h31, 1'b0);
    expect_acc(0, 8'h31);
    wait_drain("hold", 200);
    check_order("hold_first");
    push(1, 8'hD1, 1'b1);
    repeat (30) @(posedge clk);
    #1;
    chk("hold_grant", 32'(grant), 32'(2'b01));
    chk("hold_no_accept", 32'(act_q.size() - act_rd), 0);
    push(0, 8'h32, 1'b1);
    expect_acc(0, 8'h32);
    expect_acc(1, 8'hD1);
    wait_drain("hold_end", 200);
    check_order("hold_order");

    // timeout with tx_busy tied low; rr unchanged afterwards
    busy_len = 0;
    push(0, 8'h41, 1'b1);
    expect_acc(0, 8'h41);
    wait_drain("timeout", 100);
    check_order("timeout_accept");
    chk("timeout_latency", 32'(last_to_cyc - last_start_cyc), T);
    chk("timeout_grant", 32'(grant), 0);
    busy_len = 3;
    push(0, 8'h42, 1'b1);
    push(1, 8'hE1, 1'b1);
    expect_acc(0, 8'h42);
    expect_acc(1, 8'hE1);
    wait_drain("post_timeout", 200);
    check_order("post_timeout_order");

    // reset during WAIT_DONE, then requester 1 sends 8'hA3
    busy_len = 10;
    push(0, 8'h51, 1'b1);
    expect_acc(0, 8'h51);
    n = 0;
    while (!m_acked) begin
      @(posedge clk);
      #1;
      n++;
      if (n > 50) begin
        n_chk++;
        n_err++;
        $display("FAIL midframe_ack: got no tx_busy ack in 50 cycles, want ack");
        break;
      end
    end
    @(posedge clk);
    #1;
    chk("midframe_state", 32'(dbg_state), 32'(2'd3));
    chk("midframe_grant", 32'(grant), 32'(2'b01));
    #2;
    rst_n = 1'b0;
    #1;
    chk("reset_async_outputs", 32'({tx_data, tx_start, req0_ready, req1_ready, grant, timeout_err, dbg_state}), 0);
    push(1, 8'hA3, 1'b1);
    expect_acc(1, 8'hA3);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    rel = cyc;
    wait_drain("after_reset", 200);
    check_order("after_reset_order");
    chk("first_select_after_reset", 32'(acc_cyc_q[acc_cyc_q.size()-1] - rel), 1);
    chk("after_reset_tx_data", 32'(tx_data), 32'hA3);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
